// File: rtl/uart_echo_host.sv
// Host-side echo initiator: streams an incrementing byte sequence into uart_core,
// checks each returned echo (exact or ASCII case-flipped) and reports pass/fail.
module uart_echo_host #(
   parameter int unsigned N_PACKETS      = 50,
   parameter logic [7:0]  START_CHAR     = 8'h41,
   parameter int unsigned TIMEOUT_CYCLES = 1_225_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic       timeout,
   output logic [7:0] err_cnt,
   output logic [7:0] pkt_cnt
);

   localparam int unsigned       TIMER_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
   localparam logic [7:0]        PKT_LAST   = 8'(N_PACKETS);
   localparam logic [7:0]        CASE_DELTA = 8'h20;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_ECHO,
      S_CHECK,
      S_DONE
   } state_e;

   state_e               state_q;
   logic [7:0]           cur_char_q;
   logic [7:0]           echo_q;
   logic [7:0]           err_cnt_q;
   logic [7:0]           pkt_cnt_q;
   logic [TIMER_W-1:0]   timer_q;
   logic                 tx_valid_q;
   logic                 rx_ready_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 pass_q;
   logic                 timeout_q;

   logic                 echo_match;
   logic                 tx_fire;
   logic                 rx_fire;
   logic                 timer_expired;
   logic [7:0]           err_cnt_d;
   logic [7:0]           pkt_cnt_d;
   logic [7:0]           cur_char_d;

   // An echo is accepted unchanged or with the ASCII case bit flipped either way.
   always_comb begin
      echo_match = (echo_q == cur_char_q)
                || (echo_q == cur_char_q + CASE_DELTA)
                || (echo_q == cur_char_q - CASE_DELTA);
      err_cnt_d  = err_cnt_q;
      if (!echo_match && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
      pkt_cnt_d  = pkt_cnt_q + 8'd1;
      cur_char_d = cur_char_q + 8'd1;
   end

   assign tx_fire       = tx_valid_q & tx_ready;
   assign rx_fire       = rx_valid & rx_ready_q;
   assign timer_expired = (timer_q == TIMER_LAST);

   // NOTE: all state lives in one clocked block with non-blocking assignments, and the
   // synchronous reset is its first branch so it overrides start and every transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cur_char_q <= START_CHAR;
         echo_q     <= 8'h00;
         err_cnt_q  <= 8'h00;
         pkt_cnt_q  <= 8'h00;
         timer_q    <= '0;
         tx_valid_q <= 1'b0;
         rx_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q    <= S_SEND;
                  cur_char_q <= START_CHAR;
                  err_cnt_q  <= 8'h00;
                  pkt_cnt_q  <= 8'h00;
                  timeout_q  <= 1'b0;
                  done_q     <= 1'b0;
                  pass_q     <= 1'b0;
                  busy_q     <= 1'b1;
                  tx_valid_q <= 1'b1;
               end
            end

            S_SEND: begin
               if (tx_fire) begin
                  state_q    <= S_WAIT_ECHO;
                  tx_valid_q <= 1'b0;
                  rx_ready_q <= 1'b1;
                  timer_q    <= '0;
               end
            end

            S_WAIT_ECHO: begin
               if (rx_fire) begin
                  state_q    <= S_CHECK;
                  echo_q     <= rx_data;
                  rx_ready_q <= 1'b0;
               end else if (timer_expired) begin
                  state_q    <= S_DONE;
                  rx_ready_q <= 1'b0;
                  timeout_q  <= 1'b1;
                  done_q     <= 1'b1;
                  pass_q     <= 1'b0;
                  busy_q     <= 1'b0;
               end else begin
                  timer_q <= timer_q + TIMER_ONE;
               end
            end

            S_CHECK: begin
               err_cnt_q  <= err_cnt_d;
               pkt_cnt_q  <= pkt_cnt_d;
               cur_char_q <= cur_char_d;
               if (pkt_cnt_d == PKT_LAST) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  pass_q  <= (err_cnt_d == 8'h00) && !timeout_q;
               end else begin
                  state_q    <= S_SEND;
                  tx_valid_q <= 1'b1;
               end
            end

            default: begin
               state_q    <= S_IDLE;
               tx_valid_q <= 1'b0;
               rx_ready_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign tx_data  = cur_char_q;
   assign tx_valid = tx_valid_q;
   assign rx_ready = rx_ready_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign timeout  = timeout_q;
   assign err_cnt  = err_cnt_q;
   assign pkt_cnt  = pkt_cnt_q;

endmodule
